// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// It handles load-use stalls, branch flushes, halt and data-memory freezes,
// and drives the EX operand-forwarding selects.
//
// Optional feature: define HAZARD_FWD_EN to enable EX/MEM and MEM/WB
// forwarding. Without it, fwd_a/fwd_b stay 00, and any ID read that matches
// an in-flight EX or MEM destination stalls instead.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   halt, br_taken, dmem_stall     ID halt, ID taken branch, memory freeze
//   id_rs/id_rt(+_vld)             ID source indices
//   ex_rs/ex_rt(+_vld)             EX source indices (forwarding)
//   ex_memread/ex_regwrite/ex_rd   ID/EX destination info
//   mem_regwrite/mem_rd            EX/MEM destination info
//   wb_regwrite/wb_rd              MEM/WB destination info
//   pc_we, fd_we, de_we, em_we, mw_we   PC / pipeline register enables
//   fd_nop, de_nop, mw_nop         bubble insertion
//   fwd_a, fwd_b                   00 regfile, 10 EX/MEM, 01 MEM/WB
//   hz_state                       00 RUN, 01 LDSTALL, 10 HALTED
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned LD_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              br_taken,
  input  logic              dmem_stall,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_vld,
  input  logic              id_rt_vld,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_rs_vld,
  input  logic              ex_rt_vld,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              pc_we,
  output logic              fd_we,
  output logic              de_we,
  output logic              em_we,
  output logic              mw_we,
  output logic              fd_nop,
  output logic              de_nop,
  output logic              mw_nop,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        hz_state
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_HALTED  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic id_ex_hit_c;
  logic ld_use_c;
  logic raw_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // ID source matching the ID/EX destination (full-width compare, r0 included)
  assign id_ex_hit_c = (id_rs_vld && (id_rs == ex_rd)) || (id_rt_vld && (id_rt == ex_rd));
  assign ld_use_c    = ex_memread && ex_regwrite && id_ex_hit_c;

`ifdef HAZARD_FWD_EN
  // EX/MEM has priority over MEM/WB because it holds the younger result
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (mem_regwrite && ex_rs_vld && (mem_rd == ex_rs))     fwd_a_c = 2'b10;
    else if (wb_regwrite && ex_rs_vld && (wb_rd == ex_rs))  fwd_a_c = 2'b01;
    if (mem_regwrite && ex_rt_vld && (mem_rd == ex_rt))     fwd_b_c = 2'b10;
    else if (wb_regwrite && ex_rt_vld && (wb_rd == ex_rt))  fwd_b_c = 2'b01;
  end

  assign raw_c = 1'b0;
`else
  logic unused_fwd_c;

  assign fwd_a_c = 2'b00;
  assign fwd_b_c = 2'b00;

  // No bypass paths: wait out EX and MEM producers; WB writes before read
  assign raw_c = (ex_regwrite && id_ex_hit_c) ||
                 (mem_regwrite && ((id_rs_vld && (id_rs == mem_rd)) ||
                                   (id_rt_vld && (id_rt == mem_rd))));

  assign unused_fwd_c = ^{ex_rs, ex_rt, ex_rs_vld, ex_rt_vld, wb_regwrite, wb_rd};
`endif

  // Next-state and control outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_we   = 1'b1;
    fd_we   = 1'b1;
    de_we   = 1'b1;
    em_we   = 1'b1;
    mw_we   = 1'b1;
    fd_nop  = 1'b0;
    de_nop  = 1'b0;
    mw_nop  = 1'b0;
    fwd_a   = fwd_a_c;
    fwd_b   = fwd_b_c;

    if (rst) begin
      pc_we  = 1'b0;
      fd_we  = 1'b0;
      de_we  = 1'b0;
      em_we  = 1'b0;
      mw_we  = 1'b0;
      fd_nop = 1'b1;
      de_nop = 1'b1;
      mw_nop = 1'b1;
      fwd_a  = 2'b00;
      fwd_b  = 2'b00;
    end else if (dmem_stall) begin
      // Whole-pipe freeze; state and counter hold
      pc_we  = 1'b0;
      fd_we  = 1'b0;
      de_we  = 1'b0;
      em_we  = 1'b0;
      mw_we  = 1'b0;
      mw_nop = 1'b1;
    end else begin
      case (state_q)
        ST_HALTED: begin
          pc_we  = 1'b0;
          fd_we  = 1'b0;
          de_nop = 1'b1;
        end
        ST_LDSTALL: begin
          pc_we  = 1'b0;
          fd_we  = 1'b0;
          de_nop = 1'b1;
          // Counter at 1 marks the final bubble
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          if (ld_use_c) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            de_nop = 1'b1;
            if (LD_STALL > 1) begin
              state_d = ST_LDSTALL;
              cnt_d   = CNT_W'(LD_STALL - 1);
            end
          end else if (raw_c) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            de_nop = 1'b1;
          end else if (halt) begin
            state_d = ST_HALTED;
          end else if (br_taken) begin
            fd_nop = 1'b1;
          end
        end
      endcase
    end
  end

  // State and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz_state = state_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 3: register-index width.
REQ-002 Parameter LD_STALL, default 1, legal range 1..3: load-use bubble cycles.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port halt, input, 1: halt/createdump decoded in ID.
REQ-006 Port br_taken, input, 1: branch or jump resolved taken in ID.
REQ-007 Port dmem_stall, input, 1: data memory busy; global freeze request.
REQ-008 Ports id_rs and id_rt, input, REG_AW each: ID source indices.
REQ-009 Ports id_rs_vld and id_rt_vld, input, 1 each: ID source index is actually read.
REQ-010 Ports ex_rs and ex_rt, input, REG_AW each: EX source indices.
REQ-011 Ports ex_rs_vld and ex_rt_vld, input, 1 each: EX source valid.
REQ-012 Ports ex_memread, ex_regwrite (1 each) and ex_rd (REG_AW), input: ID/EX destination info.
REQ-013 Ports mem_regwrite (1) and mem_rd (REG_AW), input: EX/MEM destination info.
REQ-014 Ports wb_regwrite (1) and wb_rd (REG_AW), input: MEM/WB destination info.
REQ-015 Ports pc_we, fd_we, de_we, em_we and mw_we, output, 1 each: PC and pipeline-register write enables.
REQ-016 Ports fd_nop, de_nop and mw_nop, output, 1 each: bubble inserted into IF/ID, ID/EX and MEM/WB.
REQ-017 Ports fwd_a and fwd_b, output, 2 each: EX operand select; 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-018 Port hz_state, output, 2: FSM state; 00 RUN, 01 LDSTALL, 10 HALTED.

Function
REQ-019 Register 0 is not special; every index compare uses the full REG_AW bits.
REQ-020 Load-use hit: ex_memread & ex_regwrite & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
REQ-021 In RUN on a load-use hit: pc_we=0, fd_we=0, de_nop=1.
- LD_STALL==1: stay in RUN.
- LD_STALL>1: go to LDSTALL and load the counter with LD_STALL-1.
REQ-022 In LDSTALL: pc_we=0, fd_we=0, de_nop=1; counter decrements each unfrozen cycle; go to RUN in the cycle after the counter reaches 1.
REQ-023 br_taken in RUN without a stall: pc_we=1, fd_nop=1; the wrong-path fetch is flushed.
REQ-024 br_taken during a stall is ignored; ID holds the branch, so it re-asserts br_taken later.
REQ-025 halt in RUN without a stall: go to HALTED.
REQ-026 In HALTED: pc_we=0, fd_we=0, de_nop=1; downstream stages drain; HALTED is left only by rst.
REQ-027 dmem_stall overrides every state: all *_we=0, mw_nop=1, other nops 0; state and counter hold.
REQ-028 Priority when no override applies: dmem_stall > HALTED > LDSTALL > load-use hit > halt > br_taken.
REQ-029 In any unstalled cycle, all *_we=1 and all nops=0, except as stated above.
REQ-030 All outputs are combinational from the state, the counter and the inputs; there is no added latency.

Reset
REQ-031 While rst=1: state RUN, counter 0, all *_we=0, fd_nop=de_nop=mw_nop=1, fwd_a=fwd_b=00, hz_state=00.
REQ-032 rst asserted mid-stall or mid-freeze aborts the stall immediately.
REQ-033 The first rising edge after rst deasserts behaves as RUN.

Configuration
REQ-034 Macro HAZARD_FWD_EN defined:
- fwd_a=10 if mem_regwrite & ex_rs_vld & mem_rd==ex_rs.
- Otherwise fwd_a=01 if wb_regwrite & ex_rs_vld & wb_rd==ex_rs.
- Otherwise fwd_a=00.
- fwd_b follows the same rules using ex_rt and ex_rt_vld.
- Only load-use hits stall.
REQ-035 Macro HAZARD_FWD_EN undefined:
- fwd_a=fwd_b=00 at all times.
- A valid ID source matching ex_rd (with ex_regwrite) or mem_rd (with mem_regwrite) also produces the REQ-021 stall behaviour, re-evaluated every cycle.
- WB matches never stall; the register file writes before it reads.

Verification
REQ-036 Load-use with LD_STALL=2:
- Stimulus: ex_memread=1, ex_regwrite=1, ex_rd=3, id_rs=3, id_rs_vld=1.
- Required: pc_we=0 and de_nop=1 for exactly 2 cycles; hz_state 00 -> 01 -> 00.
REQ-037 br_taken=1 in RUN, no hazard -> fd_nop=1, pc_we=1 for one cycle; hz_state stays 00.
REQ-038 dmem_stall=1 for 3 cycles during LDSTALL:
- Required: all *_we=0, mw_nop=1; the counter holds.
- After release, exactly 1 stall cycle remains.
REQ-039 halt=1 -> hz_state=10 persists with all inputs idle for 10 cycles; rst returns it to 00 asynchronously, without a clock edge.
REQ-040 HAZARD_FWD_EN defined:
- Stimulus: mem_regwrite=1, mem_rd=5, wb_regwrite=1, wb_rd=5, ex_rs=5, ex_rs_vld=1.
- Required: fwd_a=10.
- With mem_regwrite=0 instead: fwd_a=01.
REQ-041 HAZARD_FWD_EN undefined:
- Stimulus: mem_regwrite=1, mem_rd=2, id_rt=2, id_rt_vld=1.
- Required: pc_we=0, de_nop=1, fwd_b=00.
